aes_decrypt_core: RTL and testbench

- Iterative AES-128 inverse cipher (FIPS-197 InvCipher). It is the receive-side counterpart of the existing AES encryption datapath.
- Accepts a 128-bit ciphertext and a cipher key over a valid/ready handshake, expands and stores round keys, then runs one inverse round per clock.
- Presents the plaintext under a valid/ready output handshake.
- Self-sequenced with an internal FSM; no external round controller.

---
 rtl/aes_decrypt_core.sv | 225 ++++++++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: on-chip key expansion (optionally cached), one inverse round per clock.
// Defining AES_DEC_ABORT_EN adds an abort input that cancels an in-flight block.
module aes_decrypt_core #(
   parameter int KEY_CACHE = 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] cipher_text,
   input  logic [127:0] cipher_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plain_text,
`ifdef AES_DEC_ABORT_EN
   input  logic         abort,
`endif
   output logic         busy
);

   typedef enum logic [2:0] {IDLE, KEXP, ADD10, ROUND, FINAL, DONE} state_t;

   state_t        state_q, state_d;
   logic [127:0]  blk_q, blk_d;
   logic [127:0]  pt_q, pt_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    rcon_q, rcon_d;
   logic          key_valid_q, key_valid_d;
   logic          out_valid_q, out_valid_d;
   logic [127:0]  rk_q [0:10];
   logic [127:0]  rk_d [0:10];
   logic          abort_i;
   logic          cache_hit;
   logic [127:0]  inv_core;

`ifdef AES_DEC_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // x^254 as the product x^2 * x^4 * ... * x^128; zero maps to zero
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] acc, sq;
      acc = 8'h01;
      sq  = x;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      logic [15:0] d;
      d = {b, b} << k;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] y;
      y = gf_inv(x);
      return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   // Byte n sits at row n%4, column n/4; row r rotates right by r
   function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
         o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
         o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
         o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
      end
      return o;
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = prev[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      n0 = prev[127:96] ^ t;
      n1 = prev[95:64] ^ n0;
      n2 = prev[63:32] ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   assign cache_hit = (KEY_CACHE != 0) && key_valid_q && (cipher_key == rk_q[0]);
   assign inv_core  = inv_sr_sb(blk_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = cache_hit ? ADD10 : KEXP;
         KEXP:    if (cnt_q == 4'd10) state_d = ADD10;
         ADD10:   state_d = ROUND;
         ROUND:   if (cnt_q == 4'd1) state_d = FINAL;
         FINAL:   state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_i && busy) state_d = IDLE;
   end

   always_comb begin
      in_ready = (state_q == IDLE);
      busy     = (state_q == KEXP) || (state_q == ADD10) || (state_q == ROUND) || (state_q == FINAL);
   end

   assign out_valid  = out_valid_q;
   assign plain_text = pt_q;

   always_comb begin
      blk_d       = blk_q;
      pt_d        = pt_q;
      cnt_d       = cnt_q;
      rcon_d      = rcon_q;
      key_valid_d = key_valid_q;
      out_valid_d = out_valid_q;
      rk_d        = rk_q;
      case (state_q)
         IDLE: if (in_valid) begin
            blk_d    = cipher_text;
            rk_d[0]  = cipher_key;
            if (!cache_hit) begin
               key_valid_d = 1'b0;
               cnt_d       = 4'd1;
               rcon_d      = 8'h01;
            end
         end
         KEXP: begin
            rk_d[cnt_q] = key_step(rk_q[cnt_q - 4'd1], rcon_q);
            rcon_d      = xtime(rcon_q);
            cnt_d       = cnt_q + 4'd1;
            if (cnt_q == 4'd10) key_valid_d = 1'b1;
         end
         ADD10: begin
            blk_d = blk_q ^ rk_q[10];
            cnt_d = 4'd9;
         end
         ROUND: begin
            blk_d = inv_mix(inv_core ^ rk_q[cnt_q]);
            cnt_d = cnt_q - 4'd1;
         end
         FINAL: begin
            pt_d        = inv_core ^ rk_q[0];
            out_valid_d = 1'b1;
         end
         DONE: if (out_ready) out_valid_d = 1'b0;
         default: ;
      endcase
      // An aborted block leaves the result and cache status exactly as they were
      if (abort_i && busy) begin
         pt_d        = pt_q;
         out_valid_d = out_valid_q;
         key_valid_d = key_valid_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blk_q       <= '0;
         pt_q        <= '0;
         cnt_q       <= '0;
         rcon_q      <= 8'h01;
         key_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         blk_q       <= blk_d;
         pt_q        <= pt_d;
         cnt_q       <= cnt_d;
         rcon_q      <= rcon_d;
         key_valid_q <= key_valid_d;
         out_valid_q <= out_valid_d;
      end
   end

   for (genvar gi = 0; gi < 11; gi++) begin : g_rk
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) rk_q[gi] <= '0;
         else       rk_q[gi] <= rk_d[gi];
      end
   end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Randomized bench for aes_decrypt_core: DUT plaintext is checked against a table-driven forward AES model,
// and latency against the key-cache rule. Define AES_DEC_ABORT_EN to also exercise abort.
module tb_aes_decrypt_core;
   localparam int TB_KEY_CACHE = 1;

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] cipher_text = '0;
   logic [127:0] cipher_key = '0;
   logic         in_ready, out_valid, busy;
   logic [127:0] plain_text;
`ifdef AES_DEC_ABORT_EN
   logic         abort = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]   sbox_t [256];
   bit           model_kv = 1'b0;
   logic [127:0] model_key = '0;

   always #5 clk = ~clk;

   aes_decrypt_core #(.KEY_CACHE(TB_KEY_CACHE)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .cipher_text (cipher_text),
      .cipher_key  (cipher_key),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .plain_text  (plain_text),
`ifdef AES_DEC_ABORT_EN
      .abort       (abort),
`endif
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      int p, x, y;
      p = 0; x = a; y = b;
      while (y != 0) begin
         if ((y & 1) != 0) p = p ^ x;
         x = x << 1;
         if ((x & 'h100) != 0) x = x ^ 'h11b;
         y = y >> 1;
      end
      return p[7:0];
   endfunction

   // Forward S-box from its definition: brute-force multiplicative inverse, then the affine map
   task automatic build_sbox();
      int inv, s, bv;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         s   = 0;
         for (int y = 1; y < 256; y++)
            if (x != 0 && ref_mul(x[7:0], y[7:0]) == 8'h01) inv = y;
         for (int b = 0; b < 8; b++) begin
            bv = ((inv >> b) ^ (inv >> ((b+4)%8)) ^ (inv >> ((b+5)%8)) ^ (inv >> ((b+6)%8))
                  ^ (inv >> ((b+7)%8)) ^ ('h63 >> b)) & 1;
            s = s | (bv << b);
         end
         sbox_t[x] = s[7:0];
      end
   endtask

   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tmp;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = ref_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int n = 0; n < 16; n++) t[n] = sbox_t[s[(n%4) + 4*(((n/4) + (n%4)) % 4)]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < 10) begin
               s[4*c]   = ref_mul(a0, 8'h02) ^ ref_mul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ ref_mul(a1, 8'h02) ^ ref_mul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ ref_mul(a2, 8'h02) ^ ref_mul(a3, 8'h03);
               s[4*c+3] = ref_mul(a0, 8'h03) ^ a1 ^ a2 ^ ref_mul(a3, 8'h02);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
      end
      o = '0;
      for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) chk({tag, "_in_ready_timeout"}, {127'd0, in_ready}, 128'd1);
   endtask

   task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                            input logic [127:0] exp_pt, input int hold);
      int lat, exp_lat;
      exp_lat = (TB_KEY_CACHE != 0 && model_kv && key == model_key) ? 11 : 21;
      wait_ready(tag);
      in_valid = 1'b1; cipher_text = ct; cipher_key = key;
      @(posedge clk); #1;
      in_valid = 1'b0; cipher_text = rnd128(); cipher_key = rnd128();
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 40);
      chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      chk({tag, "_plain"}, plain_text, exp_pt);
      model_kv  = 1'b1;
      model_key = key;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = (i % 2 == 0); cipher_text = rnd128(); cipher_key = rnd128();
         @(posedge clk); #1;
         chk({tag, "_hold_plain"}, plain_text, exp_pt);
         chk({tag, "_hold_in_ready"}, {127'd0, in_ready}, 128'd0);
         chk({tag, "_hold_out_valid"}, {127'd0, out_valid}, 128'd1);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_release_out_valid"}, {127'd0, out_valid}, 128'd0);
      chk({tag, "_release_in_ready"}, {127'd0, in_ready}, 128'd1);
      $display("[TB] %s key=%h ct=%h pt=%h lat=%0d exp_lat=%0d", tag, key, ct, plain_text, lat, exp_lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [127:0] key, pt, prev_key;
      build_sbox();

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
      chk("reset_busy", {127'd0, busy}, 128'd0);
      chk("reset_plain", plain_text, 128'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("reset_in_ready", {127'd0, in_ready}, 128'd1);

      run_block("vecA_expand", KEY_A, CT_A, PT_A, 0);
      run_block("vecA_cached", KEY_A, CT_A, PT_A, 5);
      run_block("vecB_newkey", KEY_B, CT_B, PT_B, 0);

      prev_key = KEY_B;
      for (int i = 0; i < 6; i++) begin
         key = (i % 2 == 1) ? prev_key : rnd128();
         pt  = rnd128();
         run_block($sformatf("rand%0d", i), key, ref_enc(pt, key), pt, $urandom_range(0, 2));
         prev_key = key;
      end
      run_block("vecB_again", KEY_B, CT_B, PT_B, 0);

      // Reset while ROUND holds r=5: 10 KEXP + ADD10 + rounds 9..6 = 15 edges after accept
      wait_ready("rst_mid");
      in_valid = 1'b1; cipher_text = CT_A; cipher_key = KEY_A;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("mid_round_busy", {127'd0, busy}, 128'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("mid_rst_busy", {127'd0, busy}, 128'd0);
      chk("mid_rst_plain", plain_text, 128'd0);
      model_kv = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
      run_block("vecA_after_rst", KEY_A, CT_A, PT_A, 0);

`ifdef AES_DEC_ABORT_EN
      wait_ready("abort");
      in_valid = 1'b1; cipher_text = CT_B; cipher_key = KEY_B;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
      chk("abort_busy", {127'd0, busy}, 128'd0);
      model_kv = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
         end
         chk("abort_no_out_valid", {127'd0, seen}, 128'd0);
      end
      run_block("vecB_after_abort", KEY_B, CT_B, PT_B, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
